// File: rtl/swb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : swb_pkg
//  Brief    : Shared types and constants for the store write buffer.
//  Revision : 1.0  initial release
// ============================================================================
package swb_pkg;

    localparam int SWB_DEPTH   = 4;
    localparam int SWB_ADDR_W  = 16;
    localparam int SWB_DATA_W  = 16;
    localparam int SWB_MEM_LAT = 4;

    // Drain sequencer states: waiting for work, single issue beat, memory busy.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } drain_state_t;

endpackage : swb_pkg
`default_nettype wire

// File: rtl/swb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : swb_fifo
//  Brief    : Store-buffer storage: circular FIFO with valid bits, write
//             merging into a queued entry and a load-forwarding CAM.
//  Revision : 1.0  initial release
// ============================================================================
module swb_fifo
    import swb_pkg::*;
#(
    parameter int DEPTH  = SWB_DEPTH,
    parameter int ADDR_W = SWB_ADDR_W,
    parameter int DATA_W = SWB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_head_lock,
    input  logic [ADDR_W-1:0] i_fwd_addr,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_fwd_hit,
    output logic [DATA_W-1:0] o_fwd_data
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    // Word-aligned compare: the byte-select bit never takes part in a match.
    localparam logic [ADDR_W-1:0] c_align_mask = ~(ADDR_W'(1));

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic [ADDR_W-1:0]  w_push_key;
    logic [ADDR_W-1:0]  w_fwd_key;
    logic               w_do_push;
    logic               w_merge_hit;
    logic [c_ptr_w-1:0] w_merge_idx;
    logic               w_append;
    logic [c_ptr_w-1:0] w_idx;

    assign w_push_key = i_push_addr & c_align_mask;
    assign w_fwd_key  = i_fwd_addr  & c_align_mask;

    // Push qualification uses the registered full flag only.
    assign w_do_push = i_push & ~o_full;
    assign w_append  = w_do_push & ~w_merge_hit;

    assign o_full      = (r_count == c_cnt_w'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];

    // CAM walk from oldest to youngest so the last match is the youngest.
    // The head is excluded from merging while its write is in flight.
    always_comb begin
        o_fwd_hit   = 1'b0;
        o_fwd_data  = '0;
        w_merge_hit = 1'b0;
        w_merge_idx = '0;
        w_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + c_ptr_w'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == w_fwd_key)) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_data[w_idx];
            end
            if (r_valid[w_idx] && (r_addr[w_idx] == w_push_key) &&
                !((k == 0) && i_head_lock)) begin
                w_merge_hit = 1'b1;
                w_merge_idx = w_idx;
            end
        end
    end

    // Entry payload: merge overwrites data in place, append fills the tail slot.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            if (w_merge_hit) begin
                r_data[w_merge_idx] <= i_push_data;
            end else begin
                r_addr[r_tail] <= w_push_key;
                r_data[r_tail] <= i_push_data;
            end
        end
    end

    // Valid bits, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_append) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_ptr_w'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_append) - c_cnt_w'(i_pop);
        end
    end

endmodule : swb_fifo
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer
//  Brief    : Write-through store buffer between the data cache and the
//             4-cycle main memory. Queues stores, drains them as single-word
//             writes while the cache fill path is idle, forwards to loads.
//  Revision : 1.0  initial release
// ============================================================================
module store_write_buffer
    import swb_pkg::*;
#(
    parameter int DEPTH   = SWB_DEPTH,
    parameter int ADDR_W  = SWB_ADDR_W,
    parameter int DATA_W  = SWB_DATA_W,
    parameter int MEM_LAT = SWB_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    input  logic              fill_req,
    input  logic              fill_busy,
    output logic              drain_busy,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int c_cnt_w = $clog2(MEM_LAT + 1);

    drain_state_t       r_state;
    drain_state_t       w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_issue;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;

    swb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (wr_req),
        .i_push_addr (wr_addr),
        .i_push_data (wr_data),
        .i_pop       (w_pop),
        .i_head_lock (drain_busy),
        .i_fwd_addr  (fwd_addr),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_fwd_hit   (fwd_hit),
        .o_fwd_data  (fwd_data)
    );

    assign full       = w_full;
    assign empty      = w_empty;
    assign drain_busy = (r_state != ST_IDLE);

    // Memory port is driven only during the single issue beat so it can be
    // ORed with the fill path.
    assign mem_enable = w_issue;
    assign mem_wr     = w_issue;
    assign mem_addr   = w_issue ? w_head_addr : '0;
    assign mem_data   = w_issue ? w_head_data : '0;

    // Drain state and memory-occupancy counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Drain sequencing: a fill request or fill in progress wins at IDLE; once
    // issued, a write always runs its full memory occupancy before the pop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !fill_req && !fill_busy) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = c_cnt_w'(MEM_LAT - 1);
            end
            ST_WAIT: begin
                if (r_cnt <= c_cnt_w'(1)) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule : store_write_buffer
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_write_buffer
//  Brief    : Randomized + directed bench for store_write_buffer with a
//             queue-based reference model and a memory-write scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_write_buffer;

    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        full;
    logic        empty;
    logic        fill_req;
    logic        fill_busy;
    logic        drain_busy;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    always #5 clk = ~clk;

    store_write_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .fill_req   (fill_req),
        .fill_busy  (fill_busy),
        .drain_busy (drain_busy),
        .mem_enable (mem_enable),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    int ntests = 0;
    int nfail  = 0;
    int nwr    = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: list of queued stores (oldest first) plus the number of
    // cycles since the current write was issued (0 = no write in progress).
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t expq[$];
    int   busy = 0;

    int   m_n0;
    int   m_j;
    bit   m_lock;
    ent_t m_e;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            expq.delete();
            busy = 0;
        end else begin
            m_n0   = mq.size();
            m_lock = (busy != 0);
            if (wr_req && m_n0 < DEPTH) begin
                m_j = -1;
                foreach (mq[i])
                    if (mq[i].a == (wr_addr & 16'hFFFE) && !(i == 0 && m_lock)) m_j = i;
                if (m_j >= 0) begin
                    mq[m_j].d = wr_data;
                end else begin
                    m_e.a = wr_addr & 16'hFFFE;
                    m_e.d = wr_data;
                    mq.push_back(m_e);
                end
            end
            if (busy == MEM_LAT) begin
                mq.delete(0);
                busy = 0;
            end else if (busy > 0) begin
                busy++;
            end else if (m_n0 > 0 && !fill_req && !fill_busy) begin
                busy = 1;
                expq.push_back(mq[0]);
            end
        end
    end

    bit          c_hit;
    logic [15:0] c_d;
    ent_t        c_e;

    // Monitor: status/forwarding against the model, memory writes against the scoreboard.
    always @(negedge clk) begin
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("drain_busy", drain_busy, busy != 0);
        chk("mem_enable", mem_enable, busy == 1);
        c_hit = 1'b0;
        c_d   = 16'h0;
        foreach (mq[i])
            if (mq[i].a == (fwd_addr & 16'hFFFE)) begin
                c_hit = 1'b1;
                c_d   = mq[i].d;
            end
        chk("fwd_hit", fwd_hit, c_hit);
        chk("fwd_data", fwd_data, c_d);
        if (mem_enable) begin
            nwr++;
            if (expq.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, want no write", mem_addr, mem_data);
            end else begin
                c_e = expq.pop_front();
                chk("mem_addr", mem_addr, c_e.a);
                chk("mem_data", mem_data, c_e.d);
                chk("mem_wr", mem_wr, 1'b1);
            end
        end else begin
            chk("mem_idle", {mem_wr, mem_addr, mem_data}, 33'h0);
        end
    end

    task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic fr, input logic fb, input logic [15:0] fa);
        wr_req    = w;
        wr_addr   = a;
        wr_data   = d;
        fill_req  = fr;
        fill_busy = fb;
        fwd_addr  = fa;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic fr, input logic fb);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, fr, fb, 16'h0);
    endtask

    task automatic wait_busy(input string nm);
        int n;
        n = 0;
        while (!drain_busy && n < 20) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
            n++;
        end
        chk(nm, drain_busy, 1'b1);
    endtask

    int          n;
    int          w0;
    logic [15:0] ra;
    logic [15:0] fa;

    initial begin
        rst = 1'b1;
        idle(2, 1'b0, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_drain_busy", drain_busy, 1'b0);
        rst = 1'b0;

        // 1: single store drains, empty again after 5 cycles
        w0 = nwr;
        step(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0010);
        n = 0;
        while (!empty && n < 20) begin
            idle(1, 1'b0, 1'b0);
            n++;
        end
        chk("t1_drain_cycles", n, 5);
        chk("t1_writes", nwr - w0, 1);

        // 2: fill the buffer while fill owns memory; 5th store dropped
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'h0020 + 16'(2 * i), 16'h2000 + 16'(i), 1'b0, 1'b1, 16'h0);
        chk("t2_full", full, 1'b1);
        step(1'b1, 16'h0028, 16'hDEAD, 1'b0, 1'b1, 16'h0028);
        chk("t2_still_full", full, 1'b1);
        w0 = nwr;
        idle(25, 1'b0, 1'b0);
        chk("t2_writes", nwr - w0, 4);

        // 3: merge into a queued entry while a different head is in flight
        step(1'b1, 16'h0050, 16'h5555, 1'b0, 1'b1, 16'h0);
        wait_busy("t3_issue");
        step(1'b1, 16'h0030, 16'h1111, 1'b0, 1'b1, 16'h0030);
        step(1'b1, 16'h0030, 16'h2222, 1'b0, 1'b1, 16'h0030);
        w0 = nwr;
        idle(15, 1'b0, 1'b0);
        chk("t3_writes", nwr - w0, 1);

        // 4: forwarding ignores address bit 0
        step(1'b1, 16'h0040, 16'hAAAA, 1'b0, 1'b1, 16'h0041);
        chk("t4_hit", fwd_hit, 1'b1);
        chk("t4_data", fwd_data, 16'hAAAA);
        fwd_addr = 16'h0042;
        #1;
        chk("t4_miss", fwd_hit, 1'b0);
        idle(8, 1'b0, 1'b0);

        // 5: fill request wins at IDLE; drain holds memory through WAIT
        step(1'b1, 16'h0060, 16'h6666, 1'b1, 1'b0, 16'h0);
        idle(3, 1'b1, 1'b0);
        chk("t5_no_issue", drain_busy, 1'b0);
        wait_busy("t5_issue");
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b1, 1'b0);
            chk("t5_busy_wait", drain_busy, 1'b1);
        end
        idle(1, 1'b1, 1'b0);
        chk("t5_released", drain_busy, 1'b0);
        chk("t5_empty", empty, 1'b1);

        // 6: reset in the second WAIT cycle with three stores queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h0070 + 16'(2 * i), 16'h7000 + 16'(i), 1'b0, 1'b1, 16'h0);
        wait_busy("t6_issue");
        idle(2, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1, 1'b0, 1'b0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_drain_busy", drain_busy, 1'b0);
        chk("t6_mem", {mem_enable, mem_wr, mem_addr, mem_data}, 34'h0);
        rst = 1'b0;

        // Random traffic: small address pool to exercise merging and forwarding
        for (int c = 0; c < 800; c++) begin
            ra = 16'h0100 + 16'(2 * $urandom_range(0, 5)) + 16'($urandom_range(0, 1));
            fa = 16'h0100 + 16'(2 * $urandom_range(0, 6)) + 16'($urandom_range(0, 1));
            step(($urandom_range(0, 2) != 0) && (mq.size() < DEPTH), ra, 16'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, fa);
        end

        idle(30, 1'b0, 1'b0);
        chk("final_empty", empty, 1'b1);
        chk("final_scoreboard", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule : tb_store_write_buffer
`default_nettype wire
